arm_multicycle_core: RTL and testbench
======================================

# arm_multicycle_core

Parametrised multi-cycle successor to the team's single-cycle ARM-subset CPU. Fetch, decode, execute, memory and writeback run as a five-state FSM over synchronous code and data RAMs, so loads are timing-correct. Adds the full ARM condition set on every instruction, a complete NZCV flag model, rotated immediates and a program-load port. Sits at the top of the FPGA demo design, driving the LED and debug ports.

## Interface
- CODE_WORDS, 16: code RAM depth in 32-bit words, power of 2, ≥2.
- DATA_WORDS, 8: data RAM depth in 32-bit words, power of 2, ≥2.
- RESET_PC, 0: PC value loaded on reset, word aligned.
- clk  in  1  clock.
- nreset  in  1  reset nreset, synchronous, active-high; clock clk.
- prog_we  in  1  writes prog_wdata into code RAM at prog_addr on the clk edge.
- prog_addr  in  $clog2(CODE_WORDS)  code RAM word index.
- prog_wdata  in  32  instruction word to load.
- dbg_reg_sel  in  4  register to observe; 15 returns the PC.
- dbg_reg_data  out  32  combinational read of the selected register.
- dbg_pc  out  32  architectural PC.
- dbg_state  out  3  FSM state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- dbg_cpsr  out  4  {N,Z,C,V}.
- retire  out  1  one-cycle pulse on the final cycle of each instruction.
- led  out  1  dbg_pc[2].

## Operation
- Registers: r0–r14 are 32 bits. Reads of r15 return PC+8.
- Code RAM fetch address is pc[2 +: log2(CODE_WORDS)], so fetch wraps modulo depth. PC itself increments modulo 2^32.
- Operand2:
  - I=1: imm8 rotated right by 2×inst[11:8].
  - I=0: Rm, unshifted. Shift fields are ignored.
- Data processing: all 16 opcodes, AND through MVN.
  - TST, TEQ, CMP and CMN never write Rd and always update flags.
  - Other opcodes update flags only when S=1.
- Flag rules:
  - N = res[31]; Z = (res==0).
  - Arithmetic ops: C = carry out, where subtraction C = NOT borrow (ARM sense). V = signed overflow of the true operation.
  - Logical ops: C and V unchanged.
  - ADC, SBC and RSC use the current C.
- Load/store (inst[27:26]=01):
  - Address = Rn ± imm12 (U bit), pre-indexed, no writeback. B and W bits are ignored.
  - Data word index = addr[2 +: log2(DATA_WORDS)], wrapping.
  - STR stores Rd; LDR loads Rd.
- Branches:
  - B/BL: target = PC+8 + sign-extended imm24<<2. BL writes r14 = PC+4.
  - BX (inst[27:4]=0x12FFF1): target = Rm with bit0 cleared.
- Conditions: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL use ARM encodings 0x0–0xE. Condition 0xF means never. A failed condition means no state change except PC+4.
- Unrecognised encodings execute as NOP (PC+4).
- Writes to Rd=15 from data processing or LDR load the PC with the value AND ~3. They do not set flags, even with S=1.

## Timing
- FETCH: present the fetch address to code RAM, registered read; go to DECODE.
- DECODE: latch IR from the RAM output; latch operand A (Rn), operand B (operand2) and the store data (Rd); go to EXEC.
- EXEC: evaluate the condition against the current CPSR.
  - Fail: PC+4, retire, go to FETCH.
  - B/BL/BX: update PC (and r14 for BL), retire, go to FETCH.
  - Data processing: latch the result and flags, go to WB. Flag-only ops do PC+4, retire and go to FETCH.
  - LDR/STR: latch the address, go to MEM.
- MEM:
  - STR: write data RAM, PC+4, retire, go to FETCH.
  - LDR: issue the registered read, go to WB.
- WB: write Rd (ALU result or RAM data), PC+4 (or the loaded PC), retire, go to FETCH.
- Instruction latency: data processing 4, LDR 5, STR 4, branch 3, flag-only op 3, condition-fail 3 cycles.
- A flag update from instruction N is visible to the condition check of instruction N+1.
- Reset (nreset=1 at an edge), any state, mid-instruction included:
  - pc=RESET_PC, state=FETCH, CPSR=0, r0–r14=0, retire=0.
  - The in-flight instruction is abandoned with no register or RAM write.
  - Code and data RAM contents are preserved.
- A prog_we write takes effect at the edge. Loading the program while nreset=1 is the supported flow. A write to the word being fetched in the same cycle returns the old word.

## Test plan
- Arithmetic loop: MOV r1,#1; ADD r2,r2,r1 ×3 → r2=3; retire every 4 cycles; dbg_pc=16 after the 4th retire.
- Flags and conditional branches:
  - SUBS r0,r1,r1 with r1=5 → {N,Z,C,V}=0110.
  - Following BNE → not taken, 3 cycles.
  - BEQ → taken to PC+8+offset.
- Overflow: ADDS r0,r1,r2 with r1=0x7FFFFFFF, r2=1 → r0=0x80000000, NZCV=1001. MOV r3,#0xFF,ROR 8 → r3=0xFF000000.
- Memory: r1=4, r2=0xA5. STR r2,[r1,#4] then LDR r3,[r1,#4] → r3=0xA5; LDR retires 5 cycles after its FETCH. Address 4+4+32 aliases the same word.
- Call and return: BL at PC=0x1C → r14=0x20 and PC=target. BX r14 → PC=0x20, 3 cycles each.
- Reset mid-instruction: assert nreset while LDR is in MEM → next cycle dbg_state=0, dbg_pc=RESET_PC, Rd unchanged, no retire pulse.

Source files
------------

// File: rtl/arm_multicycle_core.sv
// Multi-cycle ARM-subset core: FETCH/DECODE/EXEC/MEM/WB over synchronous code and data RAMs.
// Full condition set, NZCV flags, rotated immediates, and a program-load port into code RAM.
module arm_multicycle_core #(
  parameter int          CODE_WORDS = 16,
  parameter int          DATA_WORDS = 8,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic                          clk,
  input  logic                          nreset,
  input  logic                          prog_we,
  input  logic [$clog2(CODE_WORDS)-1:0] prog_addr,
  input  logic [31:0]                   prog_wdata,
  input  logic [3:0]                    dbg_reg_sel,
  output logic [31:0]                   dbg_reg_data,
  output logic [31:0]                   dbg_pc,
  output logic [2:0]                    dbg_state,
  output logic [3:0]                    dbg_cpsr,
  output logic                          retire,
  output logic                          led
);
  localparam int CW = $clog2(CODE_WORDS);
  localparam int DW = $clog2(DATA_WORDS);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4
  } state_t;

  state_t        state, state_nx;
  logic [31:0]   code_mem [CODE_WORDS];
  logic [31:0]   data_mem [DATA_WORDS];
  logic [31:0]   regs [16];
  logic [31:0]   code_q, ir, pc, op_a, op_b, st_data, res_q, data_q, wb_val;
  logic [3:0]    cpsr, nzcv_q;
  logic [DW-1:0] daddr_q;

  // Reads of r15 see the pipeline-visible PC+8.
  function automatic logic [31:0] rd_reg(input logic [3:0] r);
    return (r == 4'd15) ? pc + 32'd8 : regs[r];
  endfunction

  // Decode-stage operand2 immediate: imm8 rotated right by twice the rotate field.
  logic [31:0] d_imm8, d_imm_rot;
  logic [4:0]  d_rot;
  assign d_rot     = {code_q[11:8], 1'b0};
  assign d_imm8    = {24'b0, code_q[7:0]};
  assign d_imm_rot = (d_imm8 >> d_rot) | (d_imm8 << (6'd32 - {1'b0, d_rot}));

  logic [3:0] opc;
  logic is_bx, is_br, is_dp, is_ldst, is_ldr, is_str, flag_only, cond_ok;
  assign opc       = ir[24:21];
  assign is_bx     = (ir[27:4] == 24'h12FFF1);
  assign is_br     = (ir[27:25] == 3'b101);
  assign is_dp     = (ir[27:26] == 2'b00) && !is_bx;
  assign is_ldst   = (ir[27:25] == 3'b010);
  assign is_ldr    = is_ldst && ir[20];
  assign is_str    = is_ldst && !ir[20];
  assign flag_only = is_dp && (opc[3:2] == 2'b10);
  assign wb_val    = is_ldr ? data_q : res_q;

  always_comb begin
    cond_ok = 1'b0;
    case (ir[31:28])
      4'h0: cond_ok = cpsr[2];
      4'h1: cond_ok = !cpsr[2];
      4'h2: cond_ok = cpsr[1];
      4'h3: cond_ok = !cpsr[1];
      4'h4: cond_ok = cpsr[3];
      4'h5: cond_ok = !cpsr[3];
      4'h6: cond_ok = cpsr[0];
      4'h7: cond_ok = !cpsr[0];
      4'h8: cond_ok = cpsr[1] && !cpsr[2];
      4'h9: cond_ok = !cpsr[1] || cpsr[2];
      4'hA: cond_ok = (cpsr[3] == cpsr[0]);
      4'hB: cond_ok = (cpsr[3] != cpsr[0]);
      4'hC: cond_ok = !cpsr[2] && (cpsr[3] == cpsr[0]);
      4'hD: cond_ok = cpsr[2] || (cpsr[3] != cpsr[0]);
      4'hE: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  // Subtractions run as x + ~y + cin so the adder carry is the ARM not-borrow.
  logic [31:0] alu_x, alu_y, logic_res, alu_res;
  logic [32:0] alu_sum;
  logic        alu_cin, arith;
  logic [3:0]  alu_flags;
  always_comb begin
    alu_x = op_a; alu_y = op_b; alu_cin = 1'b0; arith = 1'b0; logic_res = '0;
    case (opc)
      4'h0, 4'h8: logic_res = op_a & op_b;
      4'h1, 4'h9: logic_res = op_a ^ op_b;
      4'h2, 4'hA: begin arith = 1'b1; alu_y = ~op_b; alu_cin = 1'b1; end
      4'h3:       begin arith = 1'b1; alu_x = op_b; alu_y = ~op_a; alu_cin = 1'b1; end
      4'h4, 4'hB: arith = 1'b1;
      4'h5:       begin arith = 1'b1; alu_cin = cpsr[1]; end
      4'h6:       begin arith = 1'b1; alu_y = ~op_b; alu_cin = cpsr[1]; end
      4'h7:       begin arith = 1'b1; alu_x = op_b; alu_y = ~op_a; alu_cin = cpsr[1]; end
      4'hC:       logic_res = op_a | op_b;
      4'hD:       logic_res = op_b;
      4'hE:       logic_res = op_a & ~op_b;
      default:    logic_res = ~op_b;
    endcase
    alu_sum   = {1'b0, alu_x} + {1'b0, alu_y} + {32'b0, alu_cin};
    alu_res   = arith ? alu_sum[31:0] : logic_res;
    alu_flags = {alu_res[31], alu_res == 32'd0,
                 arith ? alu_sum[32] : cpsr[1],
                 arith ? ((alu_x[31] == alu_y[31]) && (alu_res[31] != alu_x[31])) : cpsr[0]};
  end

  always_ff @(posedge clk) begin
    if (nreset) state <= S_FETCH;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = S_FETCH;
    case (state)
      S_FETCH:  state_nx = S_DECODE;
      S_DECODE: state_nx = S_EXEC;
      S_EXEC: begin
        if (cond_ok && is_dp && !flag_only) state_nx = S_WB;
        else if (cond_ok && is_ldst)        state_nx = S_MEM;
        else                                state_nx = S_FETCH;
      end
      S_MEM:    state_nx = is_ldr ? S_WB : S_FETCH;
      default:  state_nx = S_FETCH;
    endcase
  end

  always_comb begin
    retire = 1'b0;
    if (!nreset && (state != S_FETCH) && (state_nx == S_FETCH)) retire = 1'b1;
  end

  // Code RAM keeps its contents through reset; the fetch read is always registered.
  always_ff @(posedge clk) begin
    if (prog_we) code_mem[prog_addr] <= prog_wdata;
    code_q <= code_mem[pc[2 +: CW]];
  end

  always_ff @(posedge clk) begin
    if (!nreset && state == S_MEM && is_str) data_mem[daddr_q] <= st_data;
    if (state == S_MEM) data_q <= data_mem[daddr_q];
  end

  always_ff @(posedge clk) begin
    if (nreset) begin
      pc   <= RESET_PC;
      cpsr <= 4'b0;
      for (int i = 0; i < 16; i++) regs[i] <= 32'b0;
    end else begin
      case (state)
        S_DECODE: begin
          ir      <= code_q;
          op_a    <= rd_reg(code_q[19:16]);
          op_b    <= code_q[25] ? d_imm_rot : rd_reg(code_q[3:0]);
          st_data <= rd_reg(code_q[15:12]);
        end
        S_EXEC: begin
          if (!cond_ok) pc <= pc + 32'd4;
          else if (is_br) begin
            if (ir[24]) regs[14] <= pc + 32'd4;
            pc <= pc + 32'd8 + {{6{ir[23]}}, ir[23:0], 2'b00};
          end else if (is_bx) pc <= op_b & ~32'd1;
          else if (flag_only) begin
            cpsr <= alu_flags;
            pc   <= pc + 32'd4;
          end else if (is_dp) begin
            res_q  <= alu_res;
            nzcv_q <= alu_flags;
          end else if (is_ldst)
            daddr_q <= DW'((ir[23] ? op_a + {20'b0, ir[11:0]} : op_a - {20'b0, ir[11:0]}) >> 2);
          else pc <= pc + 32'd4;
        end
        S_MEM: if (!is_ldr) pc <= pc + 32'd4;
        S_WB: begin
          // A write to r15 is a jump: word-aligned, and never touches the flags.
          if (ir[15:12] == 4'd15) pc <= wb_val & ~32'd3;
          else begin
            regs[ir[15:12]] <= wb_val;
            pc <= pc + 32'd4;
            if (!is_ldr && ir[20]) cpsr <= nzcv_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign dbg_reg_data = (dbg_reg_sel == 4'd15) ? pc : regs[dbg_reg_sel];
  assign dbg_pc       = pc;
  assign dbg_state    = state;
  assign dbg_cpsr     = cpsr;
  assign led          = pc[2];
endmodule

// File: tb/tb_arm_multicycle_core.sv
// Bench for arm_multicycle_core: directed programs plus random programs, each retired
// instruction checked against an instruction-level model of the architecture.
module tb_arm_multicycle_core;
  logic        clk = 1'b0, nreset = 1'b1, prog_we = 1'b0;
  logic [3:0]  prog_addr = '0, dbg_reg_sel = '0;
  logic [31:0] prog_wdata = '0, dbg_reg_data, dbg_pc;
  logic [2:0]  dbg_state;
  logic [3:0]  dbg_cpsr;
  logic        retire, led;

  always #50 clk = ~clk;

  arm_multicycle_core #(.CODE_WORDS(16), .DATA_WORDS(8), .RESET_PC(32'h0)) dut (
    .clk(clk), .nreset(nreset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .dbg_reg_sel(dbg_reg_sel), .dbg_reg_data(dbg_reg_data),
    .dbg_pc(dbg_pc), .dbg_state(dbg_state), .dbg_cpsr(dbg_cpsr), .retire(retire), .led(led)
  );

  int checks = 0, passes = 0;
  logic [31:0] prog [16];
  logic [31:0] m_code [16];
  logic [31:0] m_regs [16];
  logic [31:0] m_dmem [8];
  logic [31:0] m_pc;
  logic [3:0]  m_cpsr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic read_reg(input int r, output logic [31:0] v);
    dbg_reg_sel = 4'(r);
    #1;
    v = dbg_reg_data;
  endtask

  function automatic logic [31:0] reg_val(input logic [3:0] r);
    return (r == 4'd15) ? m_pc + 32'd8 : m_regs[r];
  endfunction

  function automatic bit cond_holds(input logic [3:0] c);
    bit n, z, cf, v;
    {n, z, cf, v} = m_cpsr;
    case (c)
      4'h0: return z;          4'h1: return !z;
      4'h2: return cf;         4'h3: return !cf;
      4'h4: return n;          4'h5: return !n;
      4'h6: return v;          4'h7: return !v;
      4'h8: return cf && !z;   4'h9: return !cf || z;
      4'hA: return n == v;     4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ror_imm(input logic [11:0] f);
    logic [31:0] x;
    x = {24'b0, f[7:0]};
    for (int k = 0; k < 2 * int'(f[11:8]); k++) x = {x[0], x[31:1]};
    return x;
  endfunction

  // Arithmetic done on wide integers: carry and overflow read off the true result.
  task automatic alu_model(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b,
                           input logic cin, output logic [31:0] res, output logic c_o,
                           output logic v_o, output logic ar);
    longint x, y, sx, sy, k, u, s;
    bit sub, swap;
    ar = 1'b1; sub = 1'b0; swap = 1'b0; k = 0; res = '0; c_o = 1'b0; v_o = 1'b0;
    case (opc)
      4'h0, 4'h8: begin ar = 1'b0; res = a & b; end
      4'h1, 4'h9: begin ar = 1'b0; res = a ^ b; end
      4'hC:       begin ar = 1'b0; res = a | b; end
      4'hD:       begin ar = 1'b0; res = b; end
      4'hE:       begin ar = 1'b0; res = a & ~b; end
      4'hF:       begin ar = 1'b0; res = ~b; end
      4'h2, 4'hA: sub = 1'b1;
      4'h3:       begin sub = 1'b1; swap = 1'b1; end
      4'h5:       k = cin ? 1 : 0;
      4'h6:       begin sub = 1'b1; k = cin ? 0 : 1; end
      4'h7:       begin sub = 1'b1; swap = 1'b1; k = cin ? 0 : 1; end
      default:    ;
    endcase
    if (ar) begin
      x  = swap ? longint'(b) : longint'(a);
      y  = swap ? longint'(a) : longint'(b);
      sx = swap ? longint'($signed(b)) : longint'($signed(a));
      sy = swap ? longint'($signed(a)) : longint'($signed(b));
      if (sub) begin u = x - y - k; s = sx - sy - k; c_o = (x >= y + k); end
      else     begin u = x + y + k; s = sx + sy + k; c_o = (u >= 64'sd4294967296); end
      res = 32'(u);
      v_o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end
  endtask

  // Executes one instruction on the model; returns the expected cycle count.
  task automatic model_step(output int lat);
    logic [31:0] w, a, b, res, addr;
    logic [3:0]  f;
    logic        c_o, v_o, ar;
    int          rd, idx;
    w   = m_code[int'((m_pc >> 2) % 32'd16)];
    lat = 3;
    rd  = int'(w[15:12]);
    if (!cond_holds(w[31:28])) m_pc = m_pc + 32'd4;
    else if (w[27:4] == 24'h12FFF1) m_pc = reg_val(w[3:0]) & ~32'd1;
    else if (w[27:25] == 3'b101) begin
      if (w[24]) m_regs[14] = m_pc + 32'd4;
      m_pc = m_pc + 32'd8 + 32'(int'($signed(w[23:0])) * 4);
    end else if (w[27:26] == 2'b00) begin
      a = reg_val(w[19:16]);
      b = w[25] ? ror_imm(w[11:0]) : reg_val(w[3:0]);
      alu_model(w[24:21], a, b, m_cpsr[1], res, c_o, v_o, ar);
      f = {res[31], res == 32'd0, ar ? c_o : m_cpsr[1], ar ? v_o : m_cpsr[0]};
      if (w[24:21] inside {4'h8, 4'h9, 4'hA, 4'hB}) begin
        m_cpsr = f;
        m_pc = m_pc + 32'd4;
      end else begin
        lat = 4;
        if (rd == 15) m_pc = res & ~32'd3;
        else begin
          m_regs[rd] = res;
          if (w[20]) m_cpsr = f;
          m_pc = m_pc + 32'd4;
        end
      end
    end else if (w[27:25] == 3'b010) begin
      a    = reg_val(w[19:16]);
      addr = w[23] ? a + {20'b0, w[11:0]} : a - {20'b0, w[11:0]};
      idx  = int'((addr >> 2) % 32'd8);
      if (w[20]) begin
        lat = 5;
        if (rd == 15) m_pc = m_dmem[idx] & ~32'd3;
        else begin m_regs[rd] = m_dmem[idx]; m_pc = m_pc + 32'd4; end
      end else begin
        lat = 4;
        m_dmem[idx] = reg_val(w[15:12]);
        m_pc = m_pc + 32'd4;
      end
    end else m_pc = m_pc + 32'd4;
  endtask

  task automatic compare_all();
    logic [31:0] v;
    check("state_fetch", 32'(dbg_state), 32'd0);
    check("retire_low", 32'(retire), 32'd0);
    for (int r = 0; r < 15; r++) begin
      read_reg(r, v);
      check($sformatf("r%0d", r), v, m_regs[r]);
    end
    read_reg(15, v);
    check("sel15_pc", v, m_pc);
    check("pc", dbg_pc, m_pc);
    check("cpsr", 32'(dbg_cpsr), 32'(m_cpsr));
    check("led", 32'(led), 32'(m_pc[2]));
  endtask

  task automatic model_reset();
    for (int r = 0; r < 16; r++) m_regs[r] = 32'd0;
    m_pc = 32'd0;
    m_cpsr = 4'd0;
  endtask

  // Loads prog[] under reset, checks the reset state, then releases reset in a FETCH cycle.
  task automatic start_prog();
    nreset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      prog_we = 1'b1; prog_addr = 4'(i); prog_wdata = prog[i]; m_code[i] = prog[i];
      @(negedge clk);
    end
    prog_we = 1'b0;
    @(negedge clk);
    model_reset();
    compare_all();
    nreset = 1'b0;
  endtask

  task automatic run_instr(input int exp_lat);
    int cyc = 1;
    while (retire !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", 32'(cyc), 32'(exp_lat));
    @(negedge clk);
  endtask

  task automatic step(input int n);
    int lat;
    for (int i = 0; i < n; i++) begin
      model_step(lat);
      run_instr(lat);
      compare_all();
    end
  endtask

  task automatic fill_prog();
    for (int i = 0; i < 16; i++) prog[i] = 32'hE3A00000;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [3:0] cond;
    logic [31:0] w;
    cond = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hE;
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4:
        w = {cond, 2'b00, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             12'($urandom)};
      5, 6:
        w = {cond, 3'b010, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 12'($urandom_range(0, 63))};
      7: w = {cond, 3'b101, 1'($urandom_range(0, 1)), 24'(int'($urandom_range(0, 16)) - 8)};
      8: w = {cond, 24'h12FFF1, 4'($urandom_range(0, 15))};
      default: w = {cond, 2'b11, 26'($urandom)};
    endcase
    return w;
  endfunction

  initial begin
    logic [31:0] v;
    int cyc;
    for (int i = 0; i < 8; i++) m_dmem[i] = 32'd0;

    // Clear data RAM so later loads have defined contents.
    fill_prog();
    for (int i = 0; i < 8; i++) prog[i] = 32'hE5800000 | 32'(i * 4);
    start_prog();
    step(8);

    // MOV r1,#1; ADD r2,r2,r1 x3
    fill_prog();
    prog[0] = 32'hE3A01001; prog[1] = 32'hE0822001; prog[2] = 32'hE0822001; prog[3] = 32'hE0822001;
    start_prog();
    step(4);
    read_reg(2, v);
    check("loop_r2", v, 32'd3);
    check("loop_pc", dbg_pc, 32'd16);

    // MOV r1,#5; SUBS r0,r1,r1; BNE; BEQ +1
    fill_prog();
    prog[0] = 32'hE3A01005; prog[1] = 32'hE0510001; prog[2] = 32'h1A000005; prog[3] = 32'h0A000001;
    start_prog();
    step(2);
    check("subs_nzcv", 32'(dbg_cpsr), 32'b0110);
    step(1);
    check("bne_not_taken", dbg_pc, 32'h0C);
    step(1);
    check("beq_taken", dbg_pc, 32'h18);

    // MVN r1,#0x80000000; MOV r2,#1; ADDS r0,r1,r2; MOV r3,#0xFF ROR 8
    fill_prog();
    prog[0] = 32'hE3E01102; prog[1] = 32'hE3A02001; prog[2] = 32'hE0910002; prog[3] = 32'hE3A034FF;
    start_prog();
    step(4);
    read_reg(0, v);
    check("adds_r0", v, 32'h80000000);
    check("adds_nzcv", 32'(dbg_cpsr), 32'b1001);
    read_reg(3, v);
    check("ror_imm_r3", v, 32'hFF000000);

    // STR r2,[r1,#4]; LDR r3,[r1,#4]; LDR r4,[r1,#36] aliases the same word
    fill_prog();
    prog[0] = 32'hE3A01004; prog[1] = 32'hE3A020A5; prog[2] = 32'hE5812004;
    prog[3] = 32'hE5913004; prog[4] = 32'hE5914024;
    start_prog();
    step(5);
    read_reg(3, v);
    check("ldr_r3", v, 32'hA5);
    read_reg(4, v);
    check("ldr_alias_r4", v, 32'hA5);

    // BL at 0x1C to 0x30; BX r14 back to 0x20; MOV r6,#7
    fill_prog();
    prog[7] = 32'hEB000003; prog[8] = 32'hE3A06007; prog[12] = 32'hE12FFF1E;
    start_prog();
    step(7);
    step(1);
    read_reg(14, v);
    check("bl_r14", v, 32'h20);
    check("bl_pc", dbg_pc, 32'h30);
    step(1);
    check("bx_pc", dbg_pc, 32'h20);
    step(1);
    read_reg(6, v);
    check("after_return_r6", v, 32'd7);

    // Reset while LDR r5,[r0,#8] is in MEM
    fill_prog();
    prog[0] = 32'hE3A05011; prog[1] = 32'hE5905008;
    start_prog();
    step(1);
    cyc = 0;
    while (dbg_state !== 3'd3 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_mem", 32'(dbg_state), 32'd3);
    nreset = 1'b1;
    #1;
    check("rst_retire_mem", 32'(retire), 32'd0);
    @(negedge clk);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_pc", dbg_pc, 32'd0);
    check("rst_retire", 32'(retire), 32'd0);
    read_reg(5, v);
    check("rst_r5", v, 32'd0);
    model_reset();
    nreset = 1'b0;
    step(2);
    read_reg(5, v);
    check("ram_kept_r5", v, 32'hA5);

    // Random programs
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 16; i++) prog[i] = rand_instr();
      start_prog();
      step(40);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
